// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default rates, bit voter.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } uart_state_e;

    // 2-of-3 majority.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer plus 3-sample mid-bit majority voter.
// Samples at ticks H-1 and H are held; the third is the live rx_s, so
// vote is valid during the cycle whose tick is H+1.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       baud_clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [3:0] tick,
    output logic       rx_s,
    output logic       vote
);

    localparam logic [3:0] TICK_A = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_B = 4'(OVERSAMPLE / 2);

    logic rx_meta;
    logic samp_a;
    logic samp_b;

    // Two-flop synchronizer (idle-high reset) and capture of the first two votes.
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            if (tick == TICK_A) samp_a <= rx_s;
            if (tick == TICK_B) samp_b <= rx_s;
        end
    end

    assign vote = maj3(samp_a, samp_b, rx_s);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, OVERSAMPLE baud_clk cycles per bit.
// Decisions are taken on the vote edge (tick H+1); STOP leaves early so
// a start bit may immediately follow the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = 8
) (
    input  logic                 baud_clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_VOTE = 4'(OVERSAMPLE / 2 + 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    if (!(OVERSAMPLE == 8 || OVERSAMPLE == 16) || DATA_BITS != 8) begin : g_bad_param
        $error("uart_rx: OVERSAMPLE must be 8 or 16 and DATA_BITS must be 8");
    end

    uart_state_e          state, state_nxt;
    logic [3:0]           tick, tick_nxt;
    logic [2:0]           bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 done_nxt;
    logic                 ferr_nxt;
    logic                 rx_s;
    logic                 vote;
    logic                 vote_edge;
    logic                 tick_last;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .baud_clk(baud_clk),
        .reset   (reset),
        .rx      (rx),
        .tick    (tick),
        .rx_s    (rx_s),
        .vote    (vote)
    );

    assign vote_edge = (tick == TICK_VOTE);
    assign tick_last = (tick == TICK_LAST);
    assign rx_busy   = (state != IDLE);

    // State register.
    always_ff @(posedge baud_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, counters, shift register and output pulses.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_last ? 4'd0 : tick + 4'd1;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        data_nxt  = rx_data;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                tick_nxt = 4'd0;
                bit_nxt  = 3'd0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (vote_edge && vote) state_nxt = IDLE;
                else if (tick_last)    state_nxt = DATA;
            end
            DATA: begin
                if (vote_edge) shift_nxt = {vote, shift[DATA_BITS-1:1]};
                if (tick_last) begin
                    bit_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == BIT_LAST) state_nxt = STOP;
                end
            end
            STOP: begin
                if (vote_edge) begin
                    if (vote) begin
                        data_nxt  = shift;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BRK;
                    end
                end
            end
            BRK: begin
                tick_nxt = 4'd0;
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Every state entry restarts the bit timer.
        if (state_nxt != state) tick_nxt = 4'd0;
    end

    // Datapath registers.
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            tick      <= 4'd0;
            bit_cnt   <= 3'd0;
            shift     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tick      <= tick_nxt;
            bit_cnt   <= bit_nxt;
            shift     <= shift_nxt;
            rx_data   <= data_nxt;
            rx_done   <= done_nxt;
            frame_err <= ferr_nxt;
        end
    end

endmodule
